// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the rk16 ALU built-in self-test sequencer.
// Holds the FSM encoding, the operand pattern table and the MISR defaults.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int NUM_PAT = 5;
  localparam int NUM_SEL = 16;

  localparam logic [15:0] PAT_A [NUM_PAT] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
  localparam logic [15:0] PAT_B [NUM_PAT] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h5678};

  localparam logic [2:0] LAST_PAT = 3'(NUM_PAT - 1);
  localparam logic [3:0] LAST_SEL = 4'(NUM_SEL - 1);

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register: shift-left LFSR with a parallel
// data fold-in, loadable with a seed at the start of each run.
module misr16
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_POLY,
  parameter logic [15:0] SEED = DEF_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_bist.sv
// BIST sequencer for the rk16 ALU: sweeps 16 select codes x 5 operand patterns,
// compacts every result into a MISR and flags whether the signature matches.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          SETTLE  = 0,
  parameter logic [15:0] EXP_SIG = 16'h0000,
  parameter logic [15:0] SEED    = DEF_SEED,
  parameter logic [15:0] POLY    = DEF_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] alu_out,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e      state_q, state_d;
  logic [2:0]  pat_q, pat_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        pass_q, pass_d;
  logic        misr_load, misr_en;
  logic        last_vec;
  logic [2:0]  nxt_pat;

  assign last_vec = (sel_q == LAST_SEL) && (pat_q == LAST_PAT);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    a_d       = a_q;
    b_d       = b_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    nxt_pat   = (pat_q == LAST_PAT) ? 3'd0 : pat_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          pat_d     = 3'd0;
          sel_d     = 4'd0;
          wait_d    = SETTLE_LD;
          a_d       = PAT_A[0];
          b_d       = PAT_B[0];
          pass_d    = 1'b0;
          misr_load = 1'b1;
        end
      end
      RUN: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          // Capture happens on the edge closing the vector's last settle cycle.
          misr_en = 1'b1;
          if (last_vec) begin
            state_d = DONE;
          end else begin
            pat_d  = nxt_pat;
            sel_d  = (pat_q == LAST_PAT) ? sel_q + 4'd1 : sel_q;
            a_d    = PAT_A[nxt_pat];
            b_d    = PAT_B[nxt_pat];
            wait_d = SETTLE_LD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = (signature == EXP_SIG);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= 3'd0;
      sel_q   <= 4'd0;
      wait_q  <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
    end
  end

  misr16 #(
    .POLY(POLY),
    .SEED(SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (misr_load),
    .seed (SEED),
    .en   (misr_en),
    .din  (alu_out),
    .sig  (signature)
  );

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two instances (SETTLE=0 and SETTLE=3) driven by a stub ALU,
// checked cycle by cycle against a vector-list MISR model.
module tb_alu_bist;

  function automatic logic [15:0] tab_a(input int p);
    case (p)
      1, 3:    return 16'hFFFF;
      4:       return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] tab_b(input int p);
    case (p)
      2, 3:    return 16'hFFFF;
      4:       return 16'h5678;
      default: return 16'h0000;
    endcase
  endfunction

  // Signature after the first n vectors of a sweep against the stub ALU.
  function automatic logic [15:0] model_sig(input int n, input logic [15:0] key, input bit fault);
    logic [15:0] s;
    logic [15:0] d;
    s = 16'hFFFF;
    for (int v = 0; v < n; v++) begin
      d = tab_a(v % 5) ^ tab_b(v % 5) ^ key;
      if (fault && (v / 5 == 7) && (v % 5 == 4)) d[0] = ~d[0];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = model_sig(80, 16'h0000, 1'b0);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r = 1'b0;
  int          dsel = 0;
  logic [15:0] key_v = 16'h0000;
  bit          fault_v = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        start0, start3;
  logic [15:0] a0, b0, out0, sig0, a3, b3, out3, sig3;
  logic [3:0]  sel0, sel3;
  logic        busy0, done0, pass0, busy3, done3, pass3;

  logic [15:0] o_a, o_b, o_sig;
  logic [3:0]  o_sel;
  logic        o_busy, o_done, o_pass;

  always #5 clk = ~clk;

  function automatic logic [15:0] stub(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] sel);
    logic [15:0] r;
    r = a ^ b ^ key_v;
    if (fault_v && sel == 4'd7 && a == 16'h1234 && b == 16'h5678) r[0] = ~r[0];
    return r;
  endfunction

  assign out0   = stub(a0, b0, sel0);
  assign out3   = stub(a3, b3, sel3);
  assign start0 = start_r && (dsel == 0);
  assign start3 = start_r && (dsel != 0);

  always_comb begin
    o_a    = (dsel == 0) ? a0 : a3;
    o_b    = (dsel == 0) ? b0 : b3;
    o_sel  = (dsel == 0) ? sel0 : sel3;
    o_sig  = (dsel == 0) ? sig0 : sig3;
    o_busy = (dsel == 0) ? busy0 : busy3;
    o_done = (dsel == 0) ? done0 : done3;
    o_pass = (dsel == 0) ? pass0 : pass3;
  end

  alu_bist #(.SETTLE(0), .EXP_SIG(GOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .alu_out(out0),
    .alu_a(a0), .alu_b(b0), .alu_sel(sel0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  alu_bist #(.SETTLE(3), .EXP_SIG(GOLD)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .alu_out(out3),
    .alu_a(a3), .alu_b(b3), .alu_sel(sel3),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge with the selected DUT idle.
  task automatic run(input int d, input logic [15:0] key, input bit fault,
                     input bit repulse, input int abort_at);
    int          s;
    int          v;
    logic [15:0] fin;
    s       = (d == 0) ? 0 : 3;
    dsel    = d;
    key_v   = key;
    fault_v = fault;
    fin     = model_sig(80, key, fault);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int c = 0; c < 80 * (s + 1); c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_sig", o_sig, 16'hFFFF);
        chk("abort_vec", {o_sel, o_a, o_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      v = c / (s + 1);
      chk("run_busy", o_busy, 1);
      chk("run_done", o_done, 0);
      chk("run_vec", {o_sel, o_a, o_b}, {4'(v / 5), tab_a(v % 5), tab_b(v % 5)});
      chk("run_sig", o_sig, model_sig(v, key, fault));
      start_r = repulse && (c == 10);
      @(negedge clk);
    end
    start_r = 1'b0;
    chk("done_pulse", o_done, 1);
    chk("done_busy", o_busy, 1);
    chk("done_sig", o_sig, fin);
    start_r = repulse;
    @(negedge clk);
    start_r = 1'b0;
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("final_sig", o_sig, fin);
    chk("pass", o_pass, (fin == GOLD));
    chk("hold_vec", {o_sel, o_a, o_b}, {4'hF, 16'h1234, 16'h5678});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_sig", o_sig, 16'hFFFF);
    chk("rst_sig3", sig3, 16'hFFFF);
    chk("rst_vec", {o_sel, o_a, o_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", {o_busy, o_done, o_sig}, {2'b00, 16'hFFFF});

    // Golden sweep, then back-to-back golden and random-key runs.
    run(0, 16'h0000, 1'b0, 1'b0, -1);
    run(0, 16'h0000, 1'b0, 1'b0, -1);
    run(0, 16'($urandom), 1'b0, 1'b0, -1);
    run(0, 16'h0000, 1'b0, 1'b0, -1);

    // Single-bit fault at sel=7, pat=4.
    repeat ($urandom_range(1, 4)) @(negedge clk);
    run(0, 16'h0000, 1'b1, 1'b0, -1);
    chk("fault_differs", (o_sig != GOLD), 1);

    // Multicycle settle: same signature, one capture per vector.
    run(1, 16'h0000, 1'b0, 1'b0, -1);
    run(1, 16'($urandom), 1'b0, 1'b0, -1);

    // Start re-pulsed mid-run and in the DONE cycle.
    run(0, 16'h0000, 1'b0, 1'b1, -1);

    // Reset mid-run, then a clean run.
    run(0, 16'h0000, 1'b0, 1'b0, 40);
    run(0, 16'h0000, 1'b0, 1'b0, -1);

    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(0, 16'($urandom), 1'b0, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
